// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: one CPU access at a time, IDLE->ISSUE->(WAITR)->DONE.
// Optional LSU_ALIGN_CHECK_EN: misaligned half/word accesses complete with an error and no bus cycle.
module lsu_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_sel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITR, DONE} state_t;

  state_t        state_q;
  logic [2:0]    sel_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, err_q, bvalid_q, bwe_q;
  logic [3:0]    bbe_q;
  logic [31:0]   baddr_q, bwdata_q, rdata_q;
  logic          misal;

`ifdef LSU_ALIGN_CHECK_EN
  assign misal = (cpu_sel[1:0] == 2'b01) ? cpu_addr[0]
                                         : (cpu_sel[1] && (cpu_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed lane from the full bus word, then sign/zero extend.
  function automatic logic [31:0] load_ext(input logic [2:0] sel, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (sel[1:0])
      2'b00:   return sel[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return sel[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bwe_q    <= 1'b0;
      bbe_q    <= '0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          sel_q  <= cpu_sel;
          off_q  <= cpu_addr[1:0];
          busy_q <= 1'b1;
          if (misal) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q  <= ISSUE;
            bvalid_q <= 1'b1;
            bwe_q    <= cpu_we;
            bbe_q    <= lane_be(cpu_sel[1:0], cpu_addr[1:0]);
            baddr_q  <= {cpu_addr[31:2], 2'b00};
            bwdata_q <= lane_wdata(cpu_sel[1:0], cpu_wdata);
          end
        end
        ISSUE: if (bus_ready) begin
          bvalid_q <= 1'b0;
          cnt_q    <= '0;
          if (bwe_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= WAITR;
          end
        end
        WAITR: begin
          if (bus_rvalid) begin
            rdata_q <= load_ext(sel_q, off_q, bus_rdata);
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_busy  = busy_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign bus_valid = bvalid_q;
  assign bus_we    = bwe_q;
  assign bus_be    = bbe_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;
endmodule
